// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: round-robin sharing of one combinational shifter between two
// requesters, with results queued in a small in-order response FIFO.
module shift_unit_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5,
    parameter int RESP_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_vld,
    output logic                   req0_rdy,
    input  logic [DATA_WIDTH-1:0]  req0_data,
    input  logic [SHAMT_WIDTH-1:0] req0_shamt,
    input  logic                   req0_right,
    input  logic                   req0_logical,
    input  logic                   req1_vld,
    output logic                   req1_rdy,
    input  logic [DATA_WIDTH-1:0]  req1_data,
    input  logic [SHAMT_WIDTH-1:0] req1_shamt,
    input  logic                   req1_right,
    input  logic                   req1_logical,
    output logic                   resp_vld,
    input  logic                   resp_rdy,
    output logic [DATA_WIDTH-1:0]  resp_data,
    output logic                   resp_id,
    output logic                   resp_err
);

    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    logic [CNT_W-1:0]      r_count;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic                  r_last_grant;
    logic [DATA_WIDTH-1:0] r_mem_data [RESP_DEPTH];
    logic                  r_mem_id   [RESP_DEPTH];
    logic                  r_mem_err  [RESP_DEPTH];

    logic                   w_pop;
    logic                   w_space;
    logic                   w_sel0;
    logic                   w_sel1;
    logic                   w_acc0;
    logic                   w_acc1;
    logic                   w_push;
    logic [DATA_WIDTH-1:0]  w_op_data;
    logic [SHAMT_WIDTH-1:0] w_op_shamt;
    logic                   w_op_right;
    logic                   w_op_logical;
    logic [DATA_WIDTH-1:0]  w_shift_res;
    logic                   w_shift_err;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop   = resp_vld & resp_rdy;
    assign w_space = (r_count < CNT_W'(RESP_DEPTH)) | w_pop;

    // A requester is selected whenever the other is idle, so rdy never waits on its own vld;
    // under contention the one that did not win last time gets the slot.
    assign w_sel0 = ~req1_vld | (req0_vld & r_last_grant);
    assign w_sel1 = ~req0_vld | (req1_vld & ~r_last_grant);

    assign req0_rdy = rst_n & w_space & w_sel0;
    assign req1_rdy = rst_n & w_space & w_sel1;

    assign w_acc0 = req0_vld & req0_rdy;
    assign w_acc1 = req1_vld & req1_rdy;
    assign w_push = w_acc0 | w_acc1;

    assign w_op_data    = w_acc1 ? req1_data    : req0_data;
    assign w_op_shamt   = w_acc1 ? req1_shamt   : req0_shamt;
    assign w_op_right   = w_acc1 ? req1_right   : req0_right;
    assign w_op_logical = w_acc1 ? req1_logical : req0_logical;

    // Left arithmetic has no meaning here; it is flagged and queued with a zero result.
    always_comb begin
        w_shift_res = '0;
        w_shift_err = 1'b0;
        case ({w_op_right, w_op_logical})
            2'b11:   w_shift_res = w_op_data >> w_op_shamt;
            2'b10:   w_shift_res = DATA_WIDTH'($signed(w_op_data) >>> w_op_shamt);
            2'b01:   w_shift_res = w_op_data << w_op_shamt;
            default: w_shift_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_shift_res;
            r_mem_id[r_wr_ptr]   <= w_acc1;
            r_mem_err[r_wr_ptr]  <= w_shift_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr     <= nextPtr(r_wr_ptr);
                r_last_grant <= w_acc1;
            end
            if (w_pop) begin
                r_rd_ptr <= nextPtr(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign resp_vld  = (r_count != '0);
    assign resp_data = resp_vld ? r_mem_data[r_rd_ptr] : '0;
    assign resp_id   = resp_vld ? r_mem_id[r_rd_ptr]   : 1'b0;
    assign resp_err  = resp_vld ? r_mem_err[r_rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Self-checking bench for shift_unit_arbiter: directed vector table, hand-written
// arbitration/backpressure/reset sequences, and randomized traffic against a queue model.
module tb_shift_unit_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_vld, req0_rdy, req0_right, req0_logical;
    logic [31:0] req0_data;
    logic [4:0]  req0_shamt;
    logic        req1_vld, req1_rdy, req1_right, req1_logical;
    logic [31:0] req1_data;
    logic [4:0]  req1_shamt;
    logic        resp_vld, resp_rdy, resp_id, resp_err;
    logic [31:0] resp_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          port;
        logic [31:0] data;
        logic [4:0]  shamt;
        bit          right;
        bit          logical;
        logic [31:0] expData;
        bit          expErr;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        bit          id;
        bit          err;
    } resp_t;

    vec_t  vecs[8];
    resp_t modelQ[$];
    bit    modelLast;

    shift_unit_arbiter #(.DATA_WIDTH(32), .SHAMT_WIDTH(5), .RESP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_data(req0_data),
        .req0_shamt(req0_shamt), .req0_right(req0_right), .req0_logical(req0_logical),
        .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_data(req1_data),
        .req1_shamt(req1_shamt), .req1_right(req1_right), .req1_logical(req1_logical),
        .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_data(resp_data),
        .resp_id(resp_id), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkResp(input string name, input bit vld, input logic [31:0] d,
                             input bit id, input bit err);
        checkOutput({name, "_vld"}, resp_vld, vld);
        checkOutput({name, "_data"}, resp_data, d);
        checkOutput({name, "_id"}, resp_id, id);
        checkOutput({name, "_err"}, resp_err, err);
    endtask

    task automatic clearReq();
        req0_vld = 0; req1_vld = 0;
    endtask

    task automatic applyStimulus(input bit port, input logic [31:0] d, input logic [4:0] s,
                                 input bit r, input bit l);
        if (!port) begin
            req0_vld = 1; req0_data = d; req0_shamt = s; req0_right = r; req0_logical = l;
        end else begin
            req1_vld = 1; req1_data = d; req1_shamt = s; req1_right = r; req1_logical = l;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 0;
        clearReq();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // Reference shift using plain integer arithmetic: multiply/divide by powers of two.
    function automatic logic [31:0] refShift(input logic [31:0] d, input int s, input bit r,
                                             input bit l, output bit err);
        longint p;
        longint x;
        p   = longint'(1) << s;
        err = 0;
        if (!r && !l) begin
            err = 1;
            return 32'h0;
        end
        if (!r) return 32'((longint'(d) * p) % (longint'(1) << 32));
        if (l) return 32'(longint'(d) / p);
        x = longint'($signed(d));
        if (x >= 0) return 32'(x / p);
        return 32'(-((-x + p - 1) / p));
    endfunction

    initial begin
        logic [31:0] expD;
        bit          expE;
        bit          space;
        bit          g;
        bit          popNow;
        resp_t       e;

        vecs[0] = '{0, 32'h8000_0000, 5'd4,  1, 0, 32'hF800_0000, 0};
        vecs[1] = '{1, 32'h0000_1234, 5'd3,  0, 0, 32'h0000_0000, 1};
        vecs[2] = '{1, 32'h0000_1234, 5'd4,  0, 1, 32'h0001_2340, 0};
        vecs[3] = '{0, 32'hFFFF_FFFF, 5'd31, 1, 1, 32'h0000_0001, 0};
        vecs[4] = '{1, 32'hA5A5_A5A5, 5'd0,  0, 1, 32'hA5A5_A5A5, 0};
        vecs[5] = '{0, 32'h7FFF_FFFF, 5'd31, 1, 0, 32'h0000_0000, 0};
        vecs[6] = '{1, 32'h8000_0001, 5'd1,  1, 1, 32'h4000_0000, 0};
        vecs[7] = '{0, 32'h8000_0000, 5'd31, 1, 0, 32'hFFFF_FFFF, 0};

        rst_n = 0; resp_rdy = 0;
        req0_data = 0; req0_shamt = 0; req0_right = 0; req0_logical = 0;
        req1_data = 0; req1_shamt = 0; req1_right = 0; req1_logical = 0;
        req0_vld = 1; req1_vld = 1;
        repeat (2) @(negedge clk);
        checkOutput("reset_rdy0", req0_rdy, 0);
        checkOutput("reset_rdy1", req1_rdy, 0);
        checkResp("reset", 0, 0, 0, 0);
        clearReq();
        rst_n = 1; resp_rdy = 1;
        @(negedge clk);

        $display("[TB] directed vector table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].port, vecs[i].data, vecs[i].shamt, vecs[i].right, vecs[i].logical);
            #1;
            checkOutput($sformatf("vec%0d_rdy", i), vecs[i].port ? req1_rdy : req0_rdy, 1);
            @(negedge clk);
            clearReq();
            checkResp($sformatf("vec%0d", i), 1, vecs[i].expData, vecs[i].port, vecs[i].expErr);
        end
        @(negedge clk);
        checkResp("vec_drained", 0, 0, 0, 0);

        $display("[TB] reset with two queued entries");
        resp_rdy = 0;
        applyStimulus(0, 32'h11, 5'd0, 0, 1);
        @(negedge clk);
        applyStimulus(0, 32'h22, 5'd0, 0, 1);
        @(negedge clk);
        checkResp("prereset", 1, 32'h11, 0, 0);
        rst_n = 0;
        #1;
        checkOutput("midreset_rdy0", req0_rdy, 0);
        checkResp("midreset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1; clearReq(); resp_rdy = 1;
        @(negedge clk);
        checkResp("postreset", 0, 0, 0, 0);

        $display("[TB] contended round robin");
        applyStimulus(0, 32'h1, 5'd1, 0, 1);
        applyStimulus(1, 32'h3, 5'd2, 0, 1);
        for (int k = 0; k < 8; k++) begin
            #1;
            checkOutput($sformatf("rr%0d_rdy0", k), req0_rdy, (k % 2) == 0);
            checkOutput($sformatf("rr%0d_rdy1", k), req1_rdy, (k % 2) == 1);
            if (k > 0) checkResp($sformatf("rr%0d", k), 1, ((k - 1) % 2) ? 32'd12 : 32'd2, (k - 1) % 2, 0);
            @(negedge clk);
        end
        clearReq();
        @(negedge clk);
        checkResp("rr_drained", 0, 0, 0, 0);

        $display("[TB] backpressure and full pop+push");
        resp_rdy = 0;
        applyStimulus(0, 32'hA0, 5'd0, 0, 1);
        #1 checkOutput("bp0_rdy", req0_rdy, 1);
        @(negedge clk);
        applyStimulus(0, 32'hA1, 5'd0, 0, 1);
        #1 checkOutput("bp1_rdy", req0_rdy, 1);
        checkResp("bp1", 1, 32'hA0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 32'hA2, 5'd0, 0, 1);
        #1 checkOutput("bp_full_rdy", req0_rdy, 0);
        checkResp("bp2", 1, 32'hA0, 0, 0);
        @(negedge clk);
        checkOutput("bp_hold_rdy", req0_rdy, 0);
        checkResp("bp_hold", 1, 32'hA0, 0, 0);
        resp_rdy = 1;
        #1 checkOutput("bp_poppush_rdy", req0_rdy, 1);
        @(negedge clk);
        clearReq();
        checkResp("bp_after1", 1, 32'hA1, 0, 0);
        @(negedge clk);
        checkResp("bp_after2", 1, 32'hA2, 0, 0);
        @(negedge clk);
        checkResp("bp_empty", 0, 0, 0, 0);

        $display("[TB] randomized traffic");
        doReset();
        modelQ.delete();
        modelLast = 1;
        for (int c = 0; c < 500; c++) begin
            if (modelQ.size() > 0) checkResp("rnd", 1, modelQ[0].d, modelQ[0].id, modelQ[0].err);
            else checkResp("rnd", 0, 0, 0, 0);
            req0_vld = ($urandom_range(9) < 6);
            req1_vld = ($urandom_range(9) < 6);
            req0_data = $urandom; req0_shamt = 5'($urandom_range(31));
            req0_right = 1'($urandom_range(1)); req0_logical = 1'($urandom_range(1));
            req1_data = $urandom; req1_shamt = 5'($urandom_range(31));
            req1_right = 1'($urandom_range(1)); req1_logical = 1'($urandom_range(1));
            resp_rdy = ($urandom_range(3) != 0);
            #1;
            popNow = (modelQ.size() > 0) && resp_rdy;
            space  = (modelQ.size() < DEPTH) || popNow;
            g      = (req0_vld && req1_vld) ? !modelLast : req1_vld;
            if (req0_vld) checkOutput("rnd_rdy0", req0_rdy, space && !g);
            if (req1_vld) checkOutput("rnd_rdy1", req1_rdy, space && g);
            if (popNow) void'(modelQ.pop_front());
            if (space && (req0_vld || req1_vld)) begin
                if (g) expD = refShift(req1_data, int'(req1_shamt), req1_right, req1_logical, expE);
                else   expD = refShift(req0_data, int'(req0_shamt), req0_right, req0_logical, expE);
                e.d = expD; e.id = g; e.err = expE;
                modelQ.push_back(e);
                modelLast = g;
            end
            @(negedge clk);
        end
        clearReq();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
